fp_align_stage: RTL

- Pre-add alignment stage of the 32-bit FP adder; sits directly upstream of the end-around-carry significand adder and drives its aSig, bSig, aSign and eop inputs.
- Unpacks two IEEE-754 single operands, compares exponents, swaps so the larger-exponent operand is A, and right-shifts B's significand into the extended field, collapsing lost bits into a sticky bit.
- 2-stage pipeline with valid/ready handshake on both sides. Special-operand flags pass through alongside the data.

---
 rtl/fp_align_stage_if.sv | 41 ++++
 rtl/fp_align_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_align_stage_if.sv
// fp_align_stage_if: handshake and data bus of the FP adder alignment stage.
//   Upstream side : in_valid, in_ready, opA, opB, op_sub
//   Downstream    : out_valid, out_ready, aSig, bSig, aSign, eop, exp_out,
//                   is_nan, is_inf, is_zero
//   master modport: the environment (drives operands, accepts results)
//   slave modport : the alignment stage itself
interface fp_align_stage_if #(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23
);
  localparam int OP_W   = EXP_WIDTH + SIG_WIDTH + 1;
  localparam int SIG_W2 = 2 * SIG_WIDTH + 3;

  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      opA;
  logic [OP_W-1:0]      opB;
  logic                 op_sub;
  logic                 out_valid;
  logic                 out_ready;
  logic [SIG_W2-1:0]    aSig;
  logic [SIG_W2-1:0]    bSig;
  logic                 aSign;
  logic                 eop;
  logic [EXP_WIDTH-1:0] exp_out;
  logic                 is_nan;
  logic                 is_inf;
  logic                 is_zero;

  modport master (
    output in_valid, opA, opB, op_sub, out_ready,
    input  in_ready, out_valid, aSig, bSig, aSign, eop, exp_out,
           is_nan, is_inf, is_zero
  );

  modport slave (
    input  in_valid, opA, opB, op_sub, out_ready,
    output in_ready, out_valid, aSig, bSig, aSign, eop, exp_out,
           is_nan, is_inf, is_zero
  );
endinterface

// File: rtl/fp_align_stage.sv
// fp_align_stage: pre-add alignment of the single-precision FP adder.
//   Stage 1 unpacks both operands, orders them so the larger exponent is A,
//   computes the effective operation, shift distance and special flags.
//   Stage 2 builds the 49-bit significand fields and right-aligns B with a
//   sticky bit collecting every bit shifted out.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : fp_align_stage_if.slave (operand/result handshake and data)
//   far_cnt: 16-bit saturating count of emitted transactions whose shift
//            distance exceeds SIG_WIDTH+2 (only when FP_ALIGN_PERF_CNT_EN
//            is defined)
module fp_align_stage #(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_align_stage_if.slave      bus
`ifdef FP_ALIGN_PERF_CNT_EN
  ,
  output logic [15:0]          far_cnt
`endif
);
  localparam int OP_W   = EXP_WIDTH + SIG_WIDTH + 1;
  localparam int MAN_W  = SIG_WIDTH + 1;
  localparam int SIG_W2 = 2 * SIG_WIDTH + 3;

  // ---------------- handshake ----------------
  logic s1_valid, s2_valid;
  logic s2_adv, in_ready;

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // ---------------- stage 1: unpack / compare ----------------
  logic                 sign_a, sign_b;
  logic [EXP_WIDTH-1:0] exp_a, exp_b, eexp_a, eexp_b;
  logic [SIG_WIDTH-1:0] frac_a, frac_b;
  logic [MAN_W-1:0]     man_a, man_b;
  logic                 nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic                 swap, eop_c, nan_c, inf_c, zero_c;
  logic [EXP_WIDTH-1:0] d_c;

  always_comb begin
    sign_a = bus.opA[OP_W-1];
    sign_b = bus.opB[OP_W-1];
    exp_a  = bus.opA[OP_W-2 -: EXP_WIDTH];
    exp_b  = bus.opB[OP_W-2 -: EXP_WIDTH];
    frac_a = bus.opA[SIG_WIDTH-1:0];
    frac_b = bus.opB[SIG_WIDTH-1:0];
    man_a  = {|exp_a, frac_a};
    man_b  = {|exp_b, frac_b};
    // denormals share the exponent of the smallest normal
    eexp_a = (|exp_a) ? exp_a : EXP_WIDTH'(1);
    eexp_b = (|exp_b) ? exp_b : EXP_WIDTH'(1);
    nan_a  = (&exp_a) && (|frac_a);
    nan_b  = (&exp_b) && (|frac_b);
    inf_a  = (&exp_a) && !(|frac_a);
    inf_b  = (&exp_b) && !(|frac_b);
    zero_a = !(|exp_a) && !(|frac_a);
    zero_b = !(|exp_b) && !(|frac_b);
    // exponent tie keeps opA on the A side
    swap   = exp_b > exp_a;
    eop_c  = sign_a ^ sign_b ^ bus.op_sub;
    nan_c  = nan_a || nan_b || (inf_a && inf_b && eop_c);
    inf_c  = (inf_a || inf_b) && !nan_c;
    zero_c = zero_a && zero_b;
    d_c    = swap ? (eexp_b - eexp_a) : (eexp_a - eexp_b);
  end

  logic [MAN_W-1:0]     s1_man_a, s1_man_b;
  logic [EXP_WIDTH-1:0] s1_exp, s1_d;
  logic                 s1_asign, s1_eop, s1_nan, s1_inf, s1_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_man_a <= '0;
      s1_man_b <= '0;
      s1_exp   <= '0;
      s1_d     <= '0;
      s1_asign <= 1'b0;
      s1_eop   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (bus.in_valid && in_ready) begin
      s1_man_a <= swap ? man_b : man_a;
      s1_man_b <= swap ? man_a : man_b;
      s1_exp   <= swap ? eexp_b : eexp_a;
      s1_d     <= d_c;
      s1_asign <= swap ? sign_b : sign_a;
      s1_eop   <= eop_c;
      s1_nan   <= nan_c;
      s1_inf   <= inf_c;
      s1_zero  <= zero_c;
    end
  end

  // ---------------- stage 2: align ----------------
  logic [SIG_W2-1:0]   lay_a, lay_b, bsig_c;
  logic [2*SIG_W2-1:0] wide;

  always_comb begin
    lay_a = {1'b0, s1_man_a, {MAN_W{1'b0}}};
    lay_b = {1'b0, s1_man_b, {MAN_W{1'b0}}};
    // lower half of the wide shift holds exactly the bits dropped below bit 0
    wide  = {lay_b, {SIG_W2{1'b0}}} >> s1_d;
    if (s1_d >= EXP_WIDTH'(SIG_W2 - 1))
      bsig_c = {{(SIG_W2-1){1'b0}}, |s1_man_b};
    else
      bsig_c = wide[2*SIG_W2-1 -: SIG_W2] |
               {{(SIG_W2-1){1'b0}}, |wide[SIG_W2-1:0]};
  end

  logic [SIG_W2-1:0]    s2_asig, s2_bsig;
  logic [EXP_WIDTH-1:0] s2_exp;
  logic                 s2_asign, s2_eop, s2_nan, s2_inf, s2_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_asig  <= '0;
      s2_bsig  <= '0;
      s2_exp   <= '0;
      s2_asign <= 1'b0;
      s2_eop   <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (s1_valid && s2_adv) begin
      s2_asig  <= lay_a;
      s2_bsig  <= bsig_c;
      s2_exp   <= s1_exp;
      s2_asign <= s1_asign;
      s2_eop   <= s1_eop;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_zero  <= s1_zero;
    end
  end

  // ---------------- valid pipeline ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (s2_adv)   s2_valid <= s1_valid;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.aSig      = s2_asig;
  assign bus.bSig      = s2_bsig;
  assign bus.aSign     = s2_asign;
  assign bus.eop       = s2_eop;
  assign bus.exp_out   = s2_exp;
  assign bus.is_nan    = s2_nan;
  assign bus.is_inf    = s2_inf;
  assign bus.is_zero   = s2_zero;

`ifdef FP_ALIGN_PERF_CNT_EN
  logic s2_far;

  always_ff @(posedge clk) begin
    if (!rst_n)
      s2_far <= 1'b0;
    else if (s1_valid && s2_adv)
      s2_far <= s1_d > EXP_WIDTH'(SIG_WIDTH + 2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      far_cnt <= '0;
    else if (s2_valid && bus.out_ready && s2_far && (far_cnt != '1))
      far_cnt <= far_cnt + 16'd1;
  end
`endif
endmodule
